// File: rtl/ucaspian_neuron_integrator_if.sv
// Charge-in and fire-out handshake channels of the neuron integrator.
// master = upstream/downstream side, slave = integrator.
interface ucaspian_neuron_integrator_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned POT_W  = 16
) ();
  logic [ADDR_W-1:0]       in_addr;
  logic signed [POT_W-1:0] in_charge;
  logic                    in_vld;
  logic                    in_rdy;
  logic [ADDR_W-1:0]       fire_addr;
  logic                    fire_vld;
  logic                    fire_rdy;

  modport master (
    output in_addr, in_charge, in_vld, fire_rdy,
    input  in_rdy, fire_addr, fire_vld
  );

  modport slave (
    input  in_addr, in_charge, in_vld, fire_rdy,
    output in_rdy, fire_addr, fire_vld
  );
endinterface

// File: rtl/ucaspian_neuron_integrator.sv
// Membrane potential integrator: saturating accumulate of charge packets into a potential RAM,
// threshold compare, reset-on-fire and a fire-event FIFO toward the axon stage.
module ucaspian_neuron_integrator #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned POT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_act,
  output logic                       clear_done,
  ucaspian_neuron_integrator_if.slave bus,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic signed [POT_W-1:0]    cfg_thresh,
  input  logic                       cfg_vld,
  input  logic                       next_step,
  output logic                       step_done
);
  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = FifoAw + 1;
  // Leaves room for the two packets that may still be in S1/S2.
  localparam logic [CntW-1:0] RdyLimit = CntW'(FIFO_DEPTH - 3);
  localparam logic signed [POT_W-1:0] PotMax = {1'b0, {(POT_W-1){1'b1}}};
  localparam logic signed [POT_W-1:0] PotMin = {1'b1, {(POT_W-1){1'b0}}};

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic signed [POT_W-1:0] pot_mem [Depth];
  logic signed [POT_W-1:0] thr_mem [Depth];
  logic [ADDR_W-1:0]       fifo_mem [FIFO_DEPTH];

  logic                    s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;
  logic signed [POT_W-1:0] s1_charge_q, s1_charge_d;
  logic signed [POT_W-1:0] pot_rd_q, pot_rd_d;
  logic signed [POT_W-1:0] thr_rd_q, thr_rd_d;

  logic                    s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0]       s2_addr_q, s2_addr_d;
  logic signed [POT_W-1:0] s2_wdata_q, s2_wdata_d;
  logic                    s2_fire_q, s2_fire_d;

  logic [FifoAw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   fifo_count_q, fifo_count_d;

  logic                    flush, accept, push, pop;
  logic                    pot_we;
  logic [ADDR_W-1:0]       pot_waddr;
  logic signed [POT_W-1:0] pot_wdata, pot_cur, sum_sat;
  logic [POT_W:0]          sum_wide;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = clear_act ? StClear : StRun;
        end
      end
      StRun: begin
        if (clear_act) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    flush       = (state_q == StClear) || clear_act;
    clear_done  = (state_q == StClear) && (idx_q == '1);
    bus.in_rdy  = (state_q == StRun) && !clear_act && (fifo_count_q <= RdyLimit);
    accept      = bus.in_vld && bus.in_rdy;
    bus.fire_vld  = (fifo_count_q != '0);
    bus.fire_addr = fifo_mem[rd_ptr_q];
    step_done   = (state_q == StRun) && !clear_act && !s1_vld_q && !s2_vld_q &&
                  !bus.fire_vld && !bus.in_vld && !next_step;
  end

  // Single potential write port, shared by the clear sweep and S2 write-back.
  always_comb begin
    pot_we    = 1'b0;
    pot_waddr = s2_addr_q;
    pot_wdata = s2_wdata_q;
    if (state_q == StClear) begin
      pot_we    = 1'b1;
      pot_waddr = idx_q;
      pot_wdata = '0;
    end else begin
      pot_we = s2_vld_q && !clear_act;
    end
  end

  // S0: read both RAMs; a write-back landing on the same edge is passed through so
  // the packet two behind still sees it.
  always_comb begin
    s1_vld_d    = accept;
    s1_addr_d   = bus.in_addr;
    s1_charge_d = bus.in_charge;
    thr_rd_d    = thr_mem[bus.in_addr];
    pot_rd_d    = (pot_we && (pot_waddr == bus.in_addr)) ? pot_wdata : pot_mem[bus.in_addr];
  end

  // S1: forward S2's pending write-back, saturating add, threshold compare.
  always_comb begin
    pot_cur  = (s2_vld_q && (s2_addr_q == s1_addr_q)) ? s2_wdata_q : pot_rd_q;
    sum_wide = {pot_cur[POT_W-1], pot_cur} + {s1_charge_q[POT_W-1], s1_charge_q};
    if (sum_wide[POT_W] != sum_wide[POT_W-1]) begin
      sum_sat = sum_wide[POT_W] ? PotMin : PotMax;
    end else begin
      sum_sat = sum_wide[POT_W-1:0];
    end
    s2_fire_d  = enable && (sum_sat >= thr_rd_q);
    s2_wdata_d = s2_fire_d ? '0 : sum_sat;
    s2_addr_d  = s1_addr_q;
    s2_vld_d   = s1_vld_q && !flush;
  end

  always_comb begin
    push         = s2_vld_q && s2_fire_q && !flush;
    pop          = bus.fire_vld && bus.fire_rdy;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      fifo_count_d = fifo_count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      idx_q        <= '0;
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      s1_vld_q     <= s1_vld_d;
      s2_vld_q     <= s2_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr_q   <= s1_addr_d;
    s1_charge_q <= s1_charge_d;
    pot_rd_q    <= pot_rd_d;
    thr_rd_q    <= thr_rd_d;
    s2_addr_q   <= s2_addr_d;
    s2_wdata_q  <= s2_wdata_d;
    s2_fire_q   <= s2_fire_d;
    if (pot_we)  pot_mem[pot_waddr]  <= pot_wdata;
    if (cfg_vld) thr_mem[cfg_addr]   <= cfg_thresh;
    if (push)    fifo_mem[wr_ptr_q]  <= s2_addr_q;
  end
endmodule

// File: tb/tb_ucaspian_neuron_integrator.sv
// Randomized self-checking bench: packets are applied in acceptance order to a sequential
// reference model of potentials, thresholds and the fire-event queue.
module tb_ucaspian_neuron_integrator;
  localparam int ADDR_W = 8;
  localparam int POT_W  = 16;

  logic clk = 1'b0;
  logic reset, enable, clear_act, clear_done, cfg_vld, next_step, step_done;
  logic [ADDR_W-1:0]       cfg_addr;
  logic signed [POT_W-1:0] cfg_thresh;
  logic rdy_man, rdy_rand = 1'b0, rand_mode;

  ucaspian_neuron_integrator_if #(.ADDR_W(ADDR_W), .POT_W(POT_W)) bus ();
  assign bus.fire_rdy = rand_mode ? rdy_rand : rdy_man;

  ucaspian_neuron_integrator #(.ADDR_W(ADDR_W), .POT_W(POT_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear_act  (clear_act),
    .clear_done (clear_done),
    .bus        (bus),
    .cfg_addr   (cfg_addr),
    .cfg_thresh (cfg_thresh),
    .cfg_vld    (cfg_vld),
    .next_step  (next_step),
    .step_done  (step_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int pot_m [256];
  int thr_m [256];
  int unsigned fq [$];
  bit en_m;
  int mon_exp;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_apply(input int a, input int c);
    int p;
    p = sat(pot_m[a] + c);
    if (en_m && p >= thr_m[a]) begin
      p = 0;
      fq.push_back(a);
    end
    pot_m[a] = p;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) pot_m[i] = 0;
    fq.delete();
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_en(input bit e);
    enable = e;
    en_m   = e;
  endtask

  task automatic cfg(input int a, input int t);
    cfg_addr   = 8'(a);
    cfg_thresh = 16'(t);
    cfg_vld    = 1'b1;
    thr_m[a]   = t;
    tick();
    cfg_vld = 1'b0;
  endtask

  task automatic drive(input int a, input int c);
    bus.in_addr   = 8'(a);
    bus.in_charge = 16'(c);
    bus.in_vld    = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      if (bus.in_rdy) begin
        model_apply(int'(bus.in_addr), int'(bus.in_charge));
        tick();
        return;
      end
      tick();
    end
    chk("accept_timeout", bus.in_rdy, 1);
  endtask

  task automatic send(input int a, input int c);
    drive(a, c);
    wait_accept();
  endtask

  task automatic drain(input string tag);
    bus.in_vld = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (step_done) return;
      tick();
    end
    chk(tag, step_done, 1);
  endtask

  task automatic check_pot(input int a);
    chk($sformatf("pot[%0d]", a), dut.pot_mem[a], pot_m[a]);
  endtask

  task automatic check_all_zero(input string tag);
    int nz = 0;
    for (int i = 0; i < 256; i++) if (dut.pot_mem[i] !== 16'sd0) nz++;
    chk(tag, nz, 0);
  endtask

  // Counts from 1 on the cycle of entry; the sweep's last index is the 256th cycle.
  task automatic wait_clear_done(input string tag);
    int c = 0;
    for (int k = 1; k <= 300; k++) begin
      if (clear_done) begin
        c = k;
        break;
      end
      tick();
    end
    chk(tag, c, 256);
    tick();
    chk({tag, "_pulse_end"}, clear_done, 0);
    chk({tag, "_in_rdy"}, bus.in_rdy, 1);
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset && bus.fire_vld && bus.fire_rdy) begin
      if (fq.size() != 0) mon_exp = int'(fq.pop_front());
      else mon_exp = 32'hFFFF;
      chk("fire_addr", bus.fire_addr, mon_exp);
    end
  end

  initial forever begin
    @(negedge clk);
    rdy_rand = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, c, t;
    reset = 1'b1; clear_act = 1'b0; cfg_vld = 1'b0; next_step = 1'b0;
    cfg_addr = '0; cfg_thresh = '0;
    bus.in_vld = 1'b0; bus.in_addr = '0; bus.in_charge = '0;
    rdy_man = 1'b1; rand_mode = 1'b0;
    set_en(1'b1);
    for (int i = 0; i < 256; i++) thr_m[i] = 0;
    model_clear();

    // reset and automatic sweep
    tick(3);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_fire_vld", bus.fire_vld, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_clear_done", clear_done, 0);
    reset = 1'b0;
    wait_clear_done("reset_sweep");
    check_all_zero("reset_pot_nonzero");
    tick();
    chk("idle_step_done", step_done, 1);
    next_step = 1'b1;
    #1;
    chk("next_step_masks", step_done, 0);
    tick();
    next_step = 1'b0;

    // accumulate below threshold, then cross it
    cfg(5, 100);
    send(5, 60);
    send(5, 30);
    drain("t2_drain_a");
    check_pot(5);
    send(5, 20);
    drain("t2_drain_b");
    check_pot(5);
    chk("t2_fires_pending", fq.size(), 0);

    // back-to-back packets through the forwarding paths
    cfg(7, 100);
    send(7, 40);
    send(7, 40);
    send(7, 40);
    drain("t3_drain");
    check_pot(7);
    chk("t3_fires_pending", fq.size(), 0);

    // saturation at both rails
    cfg(9, 32767);
    send(9, 30000);
    send(9, 30000);
    drain("t4_drain_a");
    check_pot(9);
    cfg(10, 0);
    send(10, -30000);
    send(10, -30000);
    drain("t4_drain_b");
    check_pot(10);

    // enable low: potentials still integrate, no fires
    cfg(11, 0);
    set_en(1'b0);
    send(11, 5);
    drain("en_drain");
    check_pot(11);
    set_en(1'b1);

    // threshold written in the same cycle as the read: old threshold wins
    cfg(20, 1000);
    cfg_addr = 8'd20; cfg_thresh = 16'sd0; cfg_vld = 1'b1;
    drive(20, 5);
    chk("t_same_cycle_rdy", bus.in_rdy, 1);
    model_apply(20, 5);
    thr_m[20] = 0;
    tick();
    cfg_vld = 1'b0;
    drain("same_cycle_drain");
    check_pot(20);
    send(20, 1);
    drain("same_cycle_drain_b");
    check_pot(20);
    chk("same_cycle_fires_pending", fq.size(), 0);

    // randomized traffic with random backpressure
    rand_mode = 1'b1;
    for (int i = 32; i < 40; i++) cfg(i, int'($urandom_range(0, 400)) - 100);
    for (int n = 0; n < 300; n++) begin
      if (n == 200) begin
        drain("rand_drain_mid");
        set_en(1'b0);
      end
      a = 32 + int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        c = int'($urandom_range(20000, 32767));
        if ($urandom_range(0, 1) == 1) c = -c;
      end else begin
        c = int'($urandom_range(0, 300)) - 100;
      end
      send(a, c);
      if ($urandom_range(0, 2) == 0) begin
        bus.in_vld = 1'b0;
        tick(int'($urandom_range(1, 2)));
      end
    end
    drain("rand_drain_end");
    rand_mode = 1'b0;
    set_en(1'b1);
    for (int i = 32; i < 40; i++) check_pot(i);
    chk("rand_fires_pending", fq.size(), 0);

    // fire FIFO backpressure: in_rdy drops at count 2, four events held, order kept
    rdy_man = 1'b0;
    for (int i = 1; i <= 6; i++) cfg(i, 0);
    for (int i = 1; i <= 4; i++) send(i, 1);
    drive(5, 1);
    tick(3);
    chk("t5_in_rdy_low", bus.in_rdy, 0);
    chk("t5_fifo_count", dut.fifo_count_q, 4);
    chk("t5_head", bus.fire_addr, 1);
    rdy_man = 1'b1;
    wait_accept();
    send(6, 1);
    drain("t5_drain");
    chk("t5_fires_pending", fq.size(), 0);

    // clear with packets in flight and events queued
    rdy_man = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1);
    bus.in_vld = 1'b0;
    chk("t6_fire_vld_before", bus.fire_vld, 1);
    clear_act = 1'b1;
    #1;
    chk("t6_in_rdy_clear_act", bus.in_rdy, 0);
    model_clear();
    tick();
    chk("t6_fire_vld_after", bus.fire_vld, 0);
    clear_act = 1'b0;
    wait_clear_done("clear_sweep");
    check_all_zero("clear_pot_nonzero");
    rdy_man = 1'b1;
    tick(2);
    chk("t6_step_done", step_done, 1);

    // reset mid-sweep restarts from index 0
    clear_act = 1'b1;
    tick();
    clear_act = 1'b0;
    tick(100);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wait_clear_done("reset_mid_sweep");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
